// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer_pkg
// Description : Shared constants, op/state/fill encodings and bit-reverse
//               helper for the multi-cycle shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

    localparam int WIDTH = 32;  // datapath width; only 32 is supported
    localparam int SHW   = 5;   // shift-amount width == number of stages

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_REV_OUT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // How the vacated high bits of a stage are filled
    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_SIGN = 2'd1,
        FILL_ROT  = 2'd2
    } fill_e;

    // Bit reversal lets the right-only core also serve left shifts
    function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One combinational right-shift stage of 2^stage bits with
//               zero, sign or rotate fill; passes work through when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] i_work,
    input  logic [2:0]       i_stage,
    input  logic             i_en,
    input  fill_e            i_fill,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_work
);

    logic [5:0]       w_amt;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_wrap;

    // Stage index only ranges 0..SHW-1, so the amount never exceeds 16
    assign w_amt     = 6'd1 << i_stage;
    assign w_shr     = i_work >> w_amt;
    assign w_hi_mask = ~({WIDTH{1'b1}} >> w_amt);
    assign w_wrap    = i_work << (6'd32 - w_amt);

    // Select the fill for the vacated high bits, or bypass the stage
    always_comb begin
        o_work = i_work;
        if (i_en) begin
            case (i_fill)
                FILL_SIGN: o_work = w_shr | (w_hi_mask & {WIDTH{i_sign}});
                FILL_ROT:  o_work = w_shr | w_wrap;
                default:   o_work = w_shr;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Handshaked multi-cycle 32-bit shifter (SRL/SRA/SLL/ROR).
//               One log-stage per clock; SLL is done by reversing the
//               operand in and the result out around a right-only core.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           r_state;
    op_e              r_op;
    logic [SHW-1:0]   r_shamt;
    logic             r_sign;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    fill_e            w_fill;
    logic [WIDTH-1:0] w_next;

    // Fill policy follows the latched op; SLL behaves as SRL on reversed data
    always_comb begin
        w_fill = FILL_ZERO;
        case (r_op)
            OP_SRA:  w_fill = FILL_SIGN;
            OP_ROR:  w_fill = FILL_ROT;
            default: w_fill = FILL_ZERO;
        endcase
    end

    shift_stage u_stage (
        .i_work  (r_work),
        .i_stage (r_cnt),
        .i_en    (r_shamt[r_cnt]),
        .i_fill  (w_fill),
        .i_sign  (r_sign),
        .o_work  (w_next)
    );

    // Control FSM, stage counter and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_SRL;
            r_shamt  <= '0;
            r_sign   <= 1'b0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_shamt <= shamt;
                        r_sign  <= data_in[WIDTH-1];
                        r_work  <= (op_e'(op) == OP_SLL) ? reverse(data_in) : data_in;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'(SHW-1)) begin
                        r_state <= ST_REV_OUT;
                    end
                end
                ST_REV_OUT: begin
                    r_result <= (r_op == OP_SLL) ? reverse(r_work) : r_work;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    // start is deliberately ignored here
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = (r_state == ST_IDLE);
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Scoreboard bench for shift_sequencer: directed cases plus
//               randomized traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    shift_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc   = -100;   // edge number of the last accepted request
    logic [31:0] model_result = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: shift semantics expressed with plain SV operators
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input logic [4:0] s);
        logic [5:0] inv;
        inv = 6'd32 - {1'b0, s};
        case (o)
            2'd0:    return d >> s;
            2'd1:    return $signed(d) >>> s;
            2'd2:    return d << s;
            default: return (s == 5'd0) ? d : ((d >> s) | (d << inv));
        endcase
    endfunction

    function automatic bit model_busy(input int c);
        return (c >= acc) && (c <= acc + 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake levels every cycle, scoreboard pop on each done
    always @(negedge clk) begin
        chk("ready", {31'b0, ready}, {31'b0, !model_busy(cyc)});
        chk("busy",  {31'b0, busy},  {31'b0, model_busy(cyc)});
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=1 want=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", 32'(cyc), 32'(e.cyc));
                model_result = e.res;
            end
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missed_done: got=0 want=1 due=%0d cyc=%0d", e.cyc, cyc);
                model_result = e.res;
            end
            chk("result_hold", result, model_result);
        end
    end

    // One cycle of stimulus, applied shortly after the rising edge
    task automatic drive(input bit s, input logic [1:0] o, input logic [31:0] d,
                         input logic [4:0] sh);
        exp_t e;
        @(posedge clk);
        #2;
        start   = s;
        op      = o;
        data_in = d;
        shamt   = sh;
        if (s && !model_busy(cyc)) begin
            acc   = cyc + 1;
            e.res = ref_shift(o, d, sh);
            e.cyc = acc + 6;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'($urandom), $urandom, 5'($urandom));
        end
    endtask

    task automatic req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh);
        drive(1'b1, o, d, sh);
        idle(8);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        data_in = 32'h0;
        shamt   = 5'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_done",   {31'b0, done},  32'h0);
        chk("reset_result", result,         32'h0);
        chk("reset_ready",  {31'b0, ready}, 32'h1);
        rst_n = 1'b1;

        // Directed cases
        req(2'd0, 32'h8000_0000, 5'd4);
        req(2'd1, 32'h8000_0000, 5'd4);
        req(2'd1, 32'h7FFF_FFFF, 5'd31);
        req(2'd2, 32'h0000_0001, 5'd31);
        req(2'd2, 32'h0000_FFFF, 5'd8);
        req(2'd3, 32'h0000_0001, 5'd1);
        req(2'd3, 32'h1234_5678, 5'd0);
        req(2'd0, 32'hDEAD_BEEF, 5'd0);
        req(2'd2, 32'hDEAD_BEEF, 5'd0);

        // Start while busy must be ignored (second pulse lands on E3)
        drive(1'b1, 2'd0, 32'hF000_0000, 5'd4);
        idle(2);
        drive(1'b1, 2'd0, 32'hFFFF_FFFF, 5'd4);
        idle(8);

        // Reset while the counter is at 2
        drive(1'b1, 2'd2, 32'hA5A5_A5A5, 5'd3);
        idle(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        acc          = -100;
        model_result = 32'h0;
        #1;
        chk("midrst_done",   {31'b0, done},  32'h0);
        chk("midrst_result", result,         32'h0);
        chk("midrst_ready",  {31'b0, ready}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req(2'd2, 32'h0000_0001, 5'd1);

        // Randomized back-to-back traffic, including starts while busy
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) == 0, 2'($urandom), $urandom, 5'($urandom));
        end
        idle(10);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
